// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan driver: active-low hex font and the digit-select off level.
package fnd_pkg;

    localparam logic [7:0] FONT_BLANK = 8'hFF;

    // Index = nibble value; bit 7 (dp) is replaced by the decoder.
    localparam logic [7:0] FONT_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic digit_off(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/fnd_font_decode.sv
// Hex nibble to active-low 7-segment font with decimal point and a dark override.
module fnd_font_decode
    import fnd_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] font
);

    always_comb begin
        font = {~dp, FONT_TABLE[value][6:0]};
        if (dark) begin
            font = FONT_BLANK;
        end
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed FND driver: prescaled digit scan, per-frame input shadowing,
// per-digit and leading-zero blanking, registered digit select and font.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned DIGITS           = 4,
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned SCAN_HZ          = 1000,
    parameter int unsigned DIGIT_ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blank,
    input  logic                  i_lzb,
    output logic [DIGITS-1:0]     o_digit,
    output logic [7:0]            o_font
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW  = $clog2(DIGITS);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic          OFF      = digit_off(DIGIT_ACTIVE_LOW != 0);

    logic [PW-1:0]         prescaler;
    logic [IW-1:0]         index;
    logic [4*DIGITS-1:0]   shadow_value;
    logic [DIGITS-1:0]     shadow_dp;
    logic [DIGITS-1:0]     shadow_blank;
    logic                  shadow_lzb;

    logic                  tick;
    logic [DIGITS-1:0]     sel_onehot;
    logic [DIGITS-1:0]     lz_dark;
    logic                  lz_run;
    logic [3:0]            cur_value;
    logic                  cur_dp;
    logic                  cur_dark;
    logic [7:0]            next_font;

    assign tick = (prescaler == PRE_LAST);

    always_comb begin
        sel_onehot = '0;
        lz_dark    = '0;
        lz_run     = shadow_lzb;
        cur_value  = '0;
        cur_dp     = 1'b0;
        cur_dark   = 1'b0;
        // Walk down from the most significant digit; blanking stops at the
        // first non-zero nibble or lit DP, and digit 0 is never considered.
        for (int unsigned k = DIGITS - 1; k > 0; k--) begin
            lz_run     = lz_run & (shadow_value[4*k +: 4] == 4'h0) & ~shadow_dp[k];
            lz_dark[k] = lz_run;
        end
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (index == IW'(k)) begin
                sel_onehot[k] = 1'b1;
                cur_value     = shadow_value[4*k +: 4];
                cur_dp        = shadow_dp[k];
                cur_dark      = shadow_blank[k] | lz_dark[k];
            end
        end
    end

    fnd_font_decode u_font (
        .value (cur_value),
        .dp    (cur_dp),
        .dark  (cur_dark),
        .font  (next_font)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prescaler    <= '0;
            index        <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '1;
            shadow_lzb   <= 1'b0;
            o_font       <= FONT_BLANK;
            o_digit      <= {DIGITS{OFF}};
        end else begin
            if (tick) begin
                prescaler <= '0;
                if (index == IDX_LAST) begin
                    index        <= '0;
                    shadow_value <= i_value;
                    shadow_dp    <= i_dp;
                    shadow_blank <= i_blank;
                    shadow_lzb   <= i_lzb;
                end else begin
                    index <= index + 1'b1;
                end
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            o_font  <= next_font;
            o_digit <= OFF ? ~sel_onehot : sel_onehot;
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with DIV=4, four active-low digits.
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lzb;
    logic [3:0]  digit;
    logic [7:0]  font;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .DIGITS           (4),
        .CLK_HZ           (8),
        .SCAN_HZ          (2),
        .DIGIT_ACTIVE_LOW (1)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_value (value),
        .i_dp    (dp),
        .i_blank (blank),
        .i_lzb   (lzb),
        .o_digit (digit),
        .o_font  (font)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks ncyc cycles of a frame starting at digit 0; f0..f3 are expected fonts of digits 0..3.
    task automatic run_frame(input string tag, input logic [7:0] f0, input logic [7:0] f1,
                             input logic [7:0] f2, input logic [7:0] f3, input int ncyc);
        logic [7:0] fx [4];
        logic [3:0] dsel;
        fx[0] = f0; fx[1] = f1; fx[2] = f2; fx[3] = f3;
        for (int c = 0; c < ncyc; c++) begin
            step();
            dsel = 4'b0001 << (c / 4);
            check($sformatf("%s font c%0d", tag, c), {24'h0, font}, {24'h0, fx[c / 4]});
            check($sformatf("%s digit c%0d", tag, c), {28'h0, digit}, {28'h0, ~dsel});
        end
    endtask

    initial begin
        reset = 1'b1;
        value = 16'h1234;
        dp    = 4'b0000;
        blank = 4'b0000;
        lzb   = 1'b0;
        step(); step(); step();
        check("reset font", {24'h0, font}, 32'hFF);
        check("reset digit", {28'h0, digit}, 32'hF);
        reset = 1'b0;

        run_frame("dark0", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16);

        // Change input mid-frame while digit 1 is on; this frame must stay 1234.
        run_frame("f1234a", 8'h99, 8'hB0, 8'hA4, 8'hF9, 6);
        value = 16'h5678;
        run_frame("f1234b", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
        for (int c = 6; c < 16; c++) begin
            step();
            check($sformatf("tear font c%0d", c), {24'h0, font},
                  (c < 8) ? 32'hB0 : (c < 12) ? 32'hA4 : 32'hF9);
        end

        value = 16'h00A0;
        lzb   = 1'b1;
        run_frame("f5678", 8'h80, 8'hF8, 8'h82, 8'h92, 16);

        value = 16'h0000;
        run_frame("lzbA0", 8'hC0, 8'h88, 8'hFF, 8'hFF, 16);

        value = 16'h0005;
        dp    = 4'b0100;
        run_frame("lzb0", 8'hC0, 8'hFF, 8'hFF, 8'hFF, 16);

        value = 16'h1234;
        dp    = 4'b0001;
        blank = 4'b0010;
        lzb   = 1'b0;
        run_frame("lzbdp", 8'h92, 8'hC0, 8'h40, 8'hFF, 16);

        run_frame("blank", 8'h19, 8'hFF, 8'hA4, 8'hF9, 16);

        // Reset while digit 2 is being shown.
        run_frame("pre_rst", 8'h19, 8'hFF, 8'hA4, 8'hF9, 9);
        reset = 1'b1;
        step();
        check("midrst font", {24'h0, font}, 32'hFF);
        check("midrst digit", {28'h0, digit}, 32'hF);
        reset = 1'b0;
        run_frame("dark1", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 16);
        run_frame("post_rst", 8'h19, 8'hFF, 8'hA4, 8'hF9, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
